spi_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SPI clock divider among up to eight requesters. For each granted requester it programs the divider with that requester's divisor (skipped when unchanged), fires one 8-pulse burst, asserts that requester's chip select for the whole burst, and returns a per-requester done pulse. It sits between the requester-side logic and the clock divider in the SPI controller.

---
 rtl/spi_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI clock divider among NUM_REQ requesters.
// Per grant: optionally reprogram the divider, fire one burst, hold chip select, pulse done.
module spi_bus_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic [8*NUM_REQ-1:0]   i_div,
   output logic [NUM_REQ-1:0]     o_grant,
   output logic [NUM_REQ-1:0]     o_cs_n,
   output logic [NUM_REQ-1:0]     o_done,
   output logic                   o_err,
   output logic                   o_busy,
   output logic [8:0]             o_div_config,
   output logic                   o_div_start_n,
   input  logic                   i_div_idle
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_CONFIG, S_CFG_WAIT, S_START, S_RUN_WAIT, S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [IW-1:0]     last_q, idx_q, pick_idx, cand;
   logic              pick_found;
   logic [7:0]        div_q, cache_div_q, pick_div;
   logic              cache_valid_q, err_q, seen_low_q;
   logic [2:0]        wait_cnt_q;
   logic              timeout, wait_exit;
   logic [NUM_REQ-1:0] idx_onehot;

   // Scan from the requester after the last one served, wrapping around.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_q;
      cand       = last_q;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((int'(last_q) + i) % NUM_REQ);
         if (!pick_found && i_req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign pick_div = i_div[8*pick_idx +: 8];

   // The divider must have dropped idle (seen_low_q) before a rising idle counts.
   assign wait_exit = seen_low_q && i_div_idle;

   always_comb begin
      state_nx = state;
      timeout  = 1'b0;
      case (state)
         S_IDLE:     if (|i_req) state_nx = S_ARB;
         S_ARB: begin
            if (!pick_found)
               state_nx = S_IDLE;
            else if (cache_valid_q && cache_div_q == pick_div)
               state_nx = S_START;
            else
               state_nx = S_CONFIG;
         end
         S_CONFIG:   state_nx = S_CFG_WAIT;
         S_CFG_WAIT: begin
            if (wait_exit)
               state_nx = S_START;
            else if (wait_cnt_q == 3'd7) begin
               timeout  = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_START:    state_nx = S_RUN_WAIT;
         S_RUN_WAIT: begin
            if (wait_exit)
               state_nx = S_DONE;
            else if (!seen_low_q && i_div_idle && wait_cnt_q == 3'd3) begin
               timeout  = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= S_IDLE;
         last_q        <= IW'(NUM_REQ - 1);
         idx_q         <= '0;
         div_q         <= '0;
         cache_div_q   <= '0;
         cache_valid_q <= 1'b0;
         err_q         <= 1'b0;
         seen_low_q    <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state <= state_nx;

         // Wait bookkeeping restarts on every state change.
         if (state != state_nx) begin
            seen_low_q <= 1'b0;
            wait_cnt_q <= '0;
         end else begin
            if (!i_div_idle) seen_low_q <= 1'b1;
            if (wait_cnt_q != 3'd7) wait_cnt_q <= wait_cnt_q + 3'd1;
         end

         if (state == S_ARB && pick_found) begin
            idx_q <= pick_idx;
            div_q <= pick_div;
            err_q <= 1'b0;
         end
         if (state == S_CONFIG) begin
            cache_div_q   <= div_q;
            cache_valid_q <= 1'b1;
         end
         if (timeout) err_q <= 1'b1;
         if (state == S_DONE) begin
            last_q <= idx_q;
            if (err_q) cache_valid_q <= 1'b0;
         end
      end
   end

   assign idx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;

   always_comb begin
      o_grant = '0;
      if (state inside {S_CONFIG, S_CFG_WAIT, S_START, S_RUN_WAIT, S_DONE})
         o_grant = idx_onehot;
   end

   assign o_cs_n        = ~o_grant;
   assign o_done        = (state == S_DONE) ? idx_onehot : '0;
   assign o_err         = (state == S_DONE) && err_q;
   assign o_busy        = (state != S_IDLE);
   assign o_div_config  = (state == S_CONFIG) ? {div_q, 1'b1} : 9'd0;
   assign o_div_start_n = (state != S_START);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter with a behavioural clock-divider model.
// Stimulus pushes expected transfers; a negedge monitor pops and compares at each o_done.
module tb_spi_bus_arbiter;

   localparam int N     = 4;
   localparam int BURST = 8;

   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic [N-1:0]   i_req = '0;
   logic [8*N-1:0] i_div = '0;
   logic [N-1:0]   o_grant, o_cs_n, o_done;
   logic           o_err, o_busy, o_div_start_n;
   logic [8:0]     o_div_config;
   logic           i_div_idle;

   spi_bus_arbiter #(.NUM_REQ(N)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_div(i_div),
      .o_grant(o_grant), .o_cs_n(o_cs_n), .o_done(o_done), .o_err(o_err),
      .o_busy(o_busy), .o_div_config(o_div_config), .o_div_start_n(o_div_start_n),
      .i_div_idle(i_div_idle)
   );

   always #5 i_clk = ~i_clk;

   // Divider model: load drops idle for one cycle, start drops it for BURST cycles.
   bit       div_dead = 1'b0;
   int       div_cnt;
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         i_div_idle <= 1'b1;
         div_cnt    <= 0;
      end else if (div_cnt != 0) begin
         div_cnt <= div_cnt - 1;
         if (div_cnt == 1) i_div_idle <= 1'b1;
      end else if (i_div_idle) begin
         if (o_div_config[0]) begin
            i_div_idle <= 1'b0;
            div_cnt    <= 1;
         end else if (!o_div_start_n && !div_dead) begin
            i_div_idle <= 1'b0;
            div_cnt    <= BURST;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      int       idx;
      bit       err;
      bit       cfg;
      logic [7:0] div;
   } exp_t;

   exp_t sb[$];

   int cyc = 0;
   always @(posedge i_clk) cyc++;

   // Monitor state
   int         done_cnt = 0;
   int         last_arb, last_start, last_done;
   bit         busy_d = 0, cfg_seen = 0, cs_bad = 0, idle_bad = 0;
   logic [7:0] cfg_val;
   logic [N-1:0] gnt_rec = '0;
   exp_t       e;

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         busy_d   = 0;
         cfg_seen = 0;
         cs_bad   = 0;
         gnt_rec  = '0;
      end else begin
         if (o_busy && !busy_d) last_arb = cyc;
         busy_d = o_busy;
         if (!o_busy && (o_grant != '0 || o_cs_n != '1 || o_done != '0 || o_err ||
                         o_div_config != '0 || !o_div_start_n))
            idle_bad = 1;
         if (o_grant != '0) begin
            if (o_cs_n !== ~o_grant) cs_bad = 1;
            if (gnt_rec == '0) gnt_rec = o_grant;
            else if (o_grant != gnt_rec) cs_bad = 1;
         end
         if (o_div_config[0]) begin
            cfg_seen = 1;
            cfg_val  = o_div_config[8:1];
         end
         if (!o_div_start_n) last_start = cyc;
         if (o_done != '0) begin
            last_done = cyc;
            done_cnt++;
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got %0h with empty scoreboard", o_done);
            end else begin
               e = sb.pop_front();
               check("done_idx", o_done, N'(1) << e.idx);
               check("grant_idx", gnt_rec, N'(1) << e.idx);
               check("err", o_err, e.err);
               check("cfg_seen", cfg_seen, e.cfg);
               if (e.cfg) check("cfg_val", cfg_val, e.div);
               check("cs_hold", cs_bad, 0);
            end
            cfg_seen = 0;
            cs_bad   = 0;
            gnt_rec  = '0;
         end
      end
   end

   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   task automatic push(input int idx, input bit err, input bit cfg, input logic [7:0] div);
      exp_t x;
      x.idx = idx; x.err = err; x.cfg = cfg; x.div = div;
      sb.push_back(x);
   endtask

   task automatic wait_grant(input int budget);
      int k = 0;
      while (o_grant == '0 && k < budget) begin tick(); k++; end
      check("wait_grant", o_grant != '0, 1);
   endtask

   task automatic wait_start(input int budget);
      int k = 0;
      while (o_div_start_n && k < budget) begin tick(); k++; end
      check("wait_start", !o_div_start_n, 1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (o_busy && k < budget) begin tick(); k++; end
      check("wait_idle", !o_busy, 1);
   endtask

   task automatic wait_dones(input int target, input int budget);
      int k = 0;
      while (done_cnt < target && k < budget) begin tick(); k++; end
      check("wait_dones", done_cnt >= target, 1);
   endtask

   // One transfer for a single requester: hold until granted, then release.
   task automatic one_shot(input int idx);
      i_req = N'(1) << idx;
      wait_grant(20);
      i_req = '0;
      wait_idle(60);
   endtask

   task automatic check_reset_outputs();
      check("rst_grant", o_grant, 0);
      check("rst_cs_n", o_cs_n, 4'hF);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      check("rst_busy", o_busy, 0);
      check("rst_cfg", o_div_config, 0);
      check("rst_start_n", o_div_start_n, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check_reset_outputs();
      repeat (2) tick();
      i_rst_n = 1'b1;
      repeat (2) tick();

      // Single requester, uncached: CONFIG emits 9'h009.
      i_div[7:0] = 8'd4;
      push(0, 0, 1, 8'd4);
      one_shot(0);
      check("uncached_arb_to_start", last_start - last_arb, 4);
      check("single_burst_len", last_done - last_start, BURST + 2);

      // Cache hit: same divisor, START right after ARB.
      push(0, 0, 0, 8'd4);
      one_shot(0);
      check("cached_arb_to_start", last_start - last_arb, 1);

      // Request dropped mid-burst still completes; odd divisor passes through.
      i_div[23:16] = 8'd9;
      push(2, 0, 1, 8'd9);
      i_req = 4'b0100;
      wait_start(20);
      tick(); tick();
      i_req = '0;
      wait_idle(60);

      // Timeout: divider never starts; cache hit on 9 then error.
      i_div[15:8] = 8'd9;
      div_dead = 1'b1;
      push(1, 1, 0, 8'd9);
      one_shot(1);
      check("timeout_start_to_done", last_done - last_start, 5);
      div_dead = 1'b0;
      // Same divisor must be reprogrammed after the error.
      push(1, 0, 1, 8'd9);
      one_shot(1);

      // Reset in the middle of a burst.
      i_div[31:24] = 8'd4;
      i_req = 4'b1000;
      wait_grant(20);
      i_req = '0;
      wait_start(20);
      tick(); tick(); tick();
      check("mid_burst_busy", o_busy, 1);
      i_rst_n = 1'b0;
      sb.delete();
      #1;
      check_reset_outputs();
      tick(); tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_rst_busy", o_busy, 0);
      end

      // Round-robin with all requests held: 0,1,2,3,0, each reprogramming.
      i_div = {8'd128, 8'd7, 8'd255, 8'd0};
      push(0, 0, 1, 8'd0);
      push(1, 0, 1, 8'd255);
      push(2, 0, 1, 8'd7);
      push(3, 0, 1, 8'd128);
      push(0, 0, 1, 8'd0);
      begin
         int target;
         target = done_cnt + 5;
         i_req = 4'b1111;
         wait_dones(target, 200);
      end
      i_req = '0;
      wait_idle(40);
      repeat (3) tick();

      check("sb_empty", sb.size(), 0);
      check("idle_outputs", idle_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
